iq_capture_packer: RTL and testbench
====================================

Name: iq_capture_packer

Overview:
- Sits directly downstream of gps_emulator.
- Consumes the quantized 3-bit real/imag baseband stream and packs 5 I/Q pairs into each 32-bit word.
- Runs a software-triggered capture of a programmed word count and streams the words out on AXI-Stream, toward a DMA engine or a host-readable buffer.
- Control and status registers are mapped into the existing register file.

Parameters:
- FIFO_DEPTH, 16, word depth of the output FIFO; must be a power of 2, ≥ 4.
- LEN_W, 16, width of the capture-length and word counters.

Ports:
- clk  in  1  system clock (same clock as gps_emulator)
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  one qualifying sample this cycle
- real_in  in  3  quantized real sample
- imag_in  in  3  quantized imag sample
- start  in  1  single-cycle capture request
- abort  in  1  single-cycle abort request
- capture_len  in  LEN_W  number of words to capture; sampled on start
- m_axis_tdata  out  32  packed word
- m_axis_tvalid  out  1  AXI-Stream valid
- m_axis_tready  in  1  AXI-Stream ready
- m_axis_tlast  out  1  marks the final word of a capture
- busy  out  1  high in CAPTURE or DRAIN
- done  out  1  one-cycle pulse when a capture completes
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- words_sent  out  LEN_W  count of completed AXIS handshakes this capture

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, packer cleared. Reset mid-operation discards everything; no done pulse.
- Pair encoding: pair = {real_in, imag_in}, 6 bits.
- Word layout:
  - pair k (k = 0..4, oldest first) occupies bits [6k+5 : 6k].
  - bits [31:30] hold the word sequence number mod 4, starting at 0 each capture.
- Pair counting: only cycles with sample_valid=1 count. Samples outside CAPTURE are ignored.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - start with capture_len ≠ 0: latch len, clear overflow, words_sent, sequence and packer; go to CAPTURE.
  - start with capture_len = 0: done pulses the next cycle; stay in IDLE.
- CAPTURE:
  - When the 5th pair is accepted in cycle t, the word is pushed into the FIFO at t+1.
  - m_axis_tvalid may rise at t+2 (FWFT FIFO, registered output).
  - tlast is stored with the word whose push index = len-1.
  - FIFO full at push: the word is dropped, overflow is set, and the push index and sequence do NOT advance. Capture continues until len words have been accepted.
  - After the last push, go to DRAIN.
- DRAIN:
  - When the tlast word handshakes (tvalid & tready): done pulses the next cycle, then go to IDLE.
- AXIS rules:
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - words_sent increments on each handshake.
- abort in CAPTURE or DRAIN:
  - Next cycle: FIFO flushed, partial word discarded, tvalid=0, go to IDLE, no done pulse, overflow retained.
  - This is the sole permitted AXIS valid withdrawal; the downstream consumer must tolerate it.
- Simultaneous events:
  - start while busy is ignored.
  - start and abort together in IDLE: abort wins, so nothing starts.
  - Push and pop in the same cycle on a full FIFO: the push is accepted.
- Wrap-around: the sequence field wraps 3→0. words_sent never exceeds len.

Decomposition:
- Shared package gps_capture_pkg holds:
  - state enum (IDLE/CAPTURE/DRAIN)
  - SAMPLE_W=3
  - PAIRS_PER_WORD=5
  - SEQ_LSB=30
  - pair/word bit-position constants
- One natural sub-module: sync_fifo_fwft. It is 33 bits wide ({tlast, tdata}) and parameterised by depth, with full/empty/flush ports.

Test Plan:
- Basic capture:
  - Stimulus: len=2, tready=1, sample_valid=1 continuously, sample k has real=k%8, imag=7-(k%8).
  - Response: word0=0x23715387 (tlast=0), word1=0x4E1F8C6A (tlast=1), done one cycle after the word1 handshake, words_sent=2.
- Sparse sample_valid:
  - Stimulus: same samples as the basic capture but sample_valid toggling 1,0,0.
  - Response: identical words; first tvalid exactly 2 cycles after the 5th valid sample.
- Overflow:
  - Stimulus: FIFO_DEPTH=16, len=20, tready=0 until the FSM reaches DRAIN, continuous samples.
  - Response: overflow=1 at the 17th completed word; 20 words delivered after tready=1; sequence field continuous 0,1,2,3,0,...; last word tlast=1.
- Zero length:
  - Stimulus: len=0, start.
  - Response: done pulses the next cycle; tvalid never rises; busy stays 0.
- Abort:
  - Stimulus: len=10, abort after 3 words are pushed and 2 pairs are pending, tready=0.
  - Response: tvalid=0 the next cycle, busy=0, no done pulse. A following start with len=1 yields first word sequence 0 with tlast=1.
- Reset mid-operation:
  - Stimulus: reset asserted during DRAIN with tvalid=1.
  - Response: all outputs 0 the next cycle, overflow cleared, FSM in IDLE.

Source files
------------

// File: rtl/gps_capture_pkg.sv
// gps_capture_pkg: shared state type and field positions for the I/Q capture packer
package gps_capture_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;
  localparam int SAMPLE_W = 3;
  localparam int PAIR_W = 2 * SAMPLE_W;
  localparam int PAIRS_PER_WORD = 5;
  localparam int PAYLOAD_W = PAIR_W * PAIRS_PER_WORD;
  localparam int WORD_W = 32;
  localparam int SEQ_LSB = 30;
  localparam int SEQ_W = WORD_W - SEQ_LSB;
  localparam int FIFO_W = WORD_W + 1;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with synchronous flush
module sync_fifo_fwft import gps_capture_pkg::*; #(
  parameter int WIDTH = FIFO_W,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr_en, rd_en;
  assign empty = cnt_q == '0;
  assign full = cnt_q[AW];
  assign rd_en = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr_en = push && (!full || rd_en);
  assign dout = empty ? '0 : mem_q[rd_q];
  always_ff @(posedge clk)
    if (reset || flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(wr_en);
      rd_q <= rd_q + AW'(rd_en);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= din;
endmodule

// File: rtl/iq_capture_packer.sv
// iq_capture_packer: packs 3-bit I/Q pairs five per word and streams a triggered capture over AXI-Stream
module iq_capture_packer import gps_capture_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] real_in,
  input  logic [SAMPLE_W-1:0] imag_in,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_W-1:0]    capture_len,
  output logic [WORD_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [LEN_W-1:0]    words_sent
);
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, idx_q, sent_q;
  logic [2:0] pcnt_q;
  logic [PAYLOAD_W-1:0] pack_q;
  logic wv_q, ovf_q, done_q, done_d;
  logic empty, full, go, go_cap, take, last_pair, push, push_ok, pop, last_word;
  always_comb begin
    go = state_q == IDLE && start && !abort;
    go_cap = go && capture_len != '0;
    take = state_q == CAPTURE && sample_valid && !abort;
    last_pair = pcnt_q == 3'(PAIRS_PER_WORD - 1);
    push = state_q == CAPTURE && wv_q && !abort;
    push_ok = !full || m_axis_tready;
    pop = m_axis_tvalid && m_axis_tready;
    last_word = idx_q == len_q - LEN_W'(1);
    done_d = (go && capture_len == '0) || (state_q == DRAIN && pop && m_axis_tlast && !abort);
    state_d = abort ? IDLE
            : go_cap ? CAPTURE
            : (push && push_ok && last_word) ? DRAIN
            : (state_q == DRAIN && pop && m_axis_tlast) ? IDLE : state_q;
  end
  // the shift register doubles as the word holding register: the push reads it the cycle after completion
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      idx_q <= '0;
      sent_q <= '0;
      pcnt_q <= '0;
      pack_q <= '0;
      wv_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      wv_q <= take && last_pair;
      if (take) pack_q <= {real_in, imag_in, pack_q[PAYLOAD_W-1:PAIR_W]};
      if (go_cap) begin
        len_q <= capture_len;
        idx_q <= '0;
        sent_q <= '0;
        pcnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (pop) sent_q <= sent_q + LEN_W'(1);
        if (push && push_ok) idx_q <= idx_q + LEN_W'(1);
        if (push && !push_ok) ovf_q <= 1'b1;
        if (abort) pcnt_q <= '0;
        else if (take) pcnt_q <= last_pair ? '0 : pcnt_q + 3'd1;
      end
    end
  sync_fifo_fwft #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(abort && busy),
    .push(push),
    .din({last_word, idx_q[SEQ_W-1:0], pack_q}),
    .pop(pop),
    .dout({m_axis_tlast, m_axis_tdata}),
    .full(full),
    .empty(empty)
  );
  assign m_axis_tvalid = !empty;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign overflow = ovf_q;
  assign words_sent = sent_q;
endmodule

// File: tb/tb_iq_capture_packer.sv
// tb_iq_capture_packer: directed and randomized captures checked against a word-level packing model
module tb_iq_capture_packer;
  localparam int LEN_W = 16;
  logic clk = 1'b0;
  logic reset, sample_valid, start, abort, m_axis_tready;
  logic [2:0] real_in, imag_in;
  logic [LEN_W-1:0] capture_len, words_sent;
  logic [31:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, busy, done, overflow;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int done_cnt = 0, done_cyc = -1, hs_cyc = -1, tv_cyc = -1, ovf_cyc = -1, rdy_mode = 0;
  logic [32:0] prev = '0;
  logic prev_stall = 1'b0;
  logic [32:0] rx_q[$];
  logic [5:0] pairs_q[$];
  int scyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iq_capture_packer #(.FIFO_DEPTH(16), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .real_in(real_in),
    .imag_in(imag_in),
    .start(start),
    .abort(abort),
    .capture_len(capture_len),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .words_sent(words_sent)
  );

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // word w of the delivered stream carries the five pairs of packed group src and sequence w mod 4
  function automatic logic [32:0] exp_word(int w, int src, int len);
    logic [31:0] d, wl;
    d = '0;
    wl = w;
    for (int k = 0; k < 5; k++) d[6*k +: 6] = pairs_q[5*src + k];
    d[31:30] = wl[1:0];
    return {w == len - 1, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int len);
    capture_len = LEN_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(int n, int gap, bit det);
    for (int i = 0; i < n; i++) begin
      real_in = det ? 3'(i % 8) : 3'($urandom);
      imag_in = det ? 3'(7 - i % 8) : 3'($urandom);
      sample_valid = 1'b1;
      pairs_q.push_back({real_in, imag_in});
      scyc_q.push_back(cyc);
      tick();
      sample_valid = 1'b0;
      repeat (gap < 0 ? int'($urandom_range(2)) : gap) begin
        real_in = 3'($urandom);
        imag_in = 3'($urandom);
        tick();
      end
    end
  endtask

  task automatic wait_done(int d0);
    for (int i = 0; i < 2000 && done_cnt == d0; i++) tick();
    check("done_seen", done_cnt, d0 + 1);
  endtask

  task automatic check_words(int len, int drop);
    check("word_count", rx_q.size(), len);
    for (int w = 0; w < len && w < rx_q.size(); w++)
      check($sformatf("word%0d", w), rx_q[w], exp_word(w, (drop >= 0 && w >= drop) ? w + 1 : w, len));
    check("words_sent", words_sent, len);
    check("done_latency", done_cyc, hs_cyc + 1);
    check("busy_end", busy, 0);
  endtask

  task automatic capture(int len, int gap, bit det, int rmode);
    int d0;
    pairs_q.delete();
    scyc_q.delete();
    rx_q.delete();
    tv_cyc = -1;
    rdy_mode = rmode;
    m_axis_tready = rmode != 0;
    d0 = done_cnt;
    do_start(len);
    send(5 * len, gap, det);
    wait_done(d0);
    check_words(len, -1);
  endtask

  initial begin
    int d0;
    logic busy_seen;
    fork
      forever begin
        @(negedge clk);
        if (prev_stall && m_axis_tvalid) check("hold", {m_axis_tlast, m_axis_tdata}, prev);
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev = {m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) begin
          rx_q.push_back(prev);
          hs_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (m_axis_tvalid && tv_cyc < 0) tv_cyc = cyc;
        if (overflow && ovf_cyc < 0) ovf_cyc = cyc;
      end
      forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 2) m_axis_tready = 1'($urandom);
      end
    join_none

    reset = 1'b1;
    sample_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    m_axis_tready = 1'b0;
    capture_len = '0;
    real_in = '0;
    imag_in = '0;
    repeat (3) tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_flags", {busy, done, overflow, m_axis_tlast}, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_sent", words_sent, 0);
    reset = 1'b0;
    tick();

    capture(2, 0, 1'b1, 1);
    check("basic_w0", rx_q[0], {1'b0, 32'h23715387});
    check("basic_w1", rx_q[1], {1'b1, 32'h4E1F8C6A});

    capture(2, 2, 1'b1, 1);
    check("sparse_w0", rx_q[0], {1'b0, 32'h23715387});
    check("sparse_w1", rx_q[1], {1'b1, 32'h4E1F8C6A});
    check("sparse_tvalid_lat", tv_cyc, scyc_q[4] + 2);

    for (int i = 0; i < 3; i++) begin
      capture(int'($urandom_range(8, 3)), -1, 1'b0, 2);
      check("rand_no_ovf", overflow, 0);
    end

    d0 = done_cnt;
    tv_cyc = -1;
    busy_seen = 1'b0;
    do_start(0);
    check("zero_done", done, 1);
    for (int i = 0; i < 5; i++) begin
      busy_seen |= busy;
      tick();
    end
    check("zero_pulses", done_cnt, d0 + 1);
    check("zero_tvalid", tv_cyc, -1);
    check("zero_busy", busy_seen, 0);

    pairs_q.delete();
    scyc_q.delete();
    rx_q.delete();
    ovf_cyc = -1;
    rdy_mode = 0;
    m_axis_tready = 1'b0;
    d0 = done_cnt;
    do_start(20);
    fork
      send(105, 0, 1'b0);
      begin
        for (int i = 0; i < 400 && !overflow; i++) tick();
        m_axis_tready = 1'b1;
      end
    join
    wait_done(d0);
    check("ovf_when", ovf_cyc, scyc_q[84] + 2);
    check_words(20, 16);
    check("ovf_sticky", overflow, 1);

    pairs_q.delete();
    rx_q.delete();
    m_axis_tready = 1'b0;
    do_start(10);
    send(17, 0, 1'b0);
    tick();
    tick();
    check("abort_pre_tvalid", m_axis_tvalid, 1);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_tvalid", m_axis_tvalid, 0);
    check("abort_busy", busy, 0);
    repeat (4) tick();
    check("abort_nodone", done_cnt, d0);
    capture(1, 0, 1'b0, 1);
    check("abort_next_hdr", rx_q[0][32:30], 3'b100);

    pairs_q.delete();
    rx_q.delete();
    rdy_mode = 0;
    m_axis_tready = 1'b0;
    do_start(20);
    fork
      send(105, 0, 1'b0);
      begin
        for (int i = 0; i < 400 && !overflow; i++) tick();
        m_axis_tready = 1'b1;
        repeat (8) tick();
        m_axis_tready = 1'b0;
      end
    join
    repeat (5) tick();
    check("drain_pre", {busy, m_axis_tvalid, overflow}, 3'b111);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_flags", {busy, done, overflow, m_axis_tlast}, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    check("mid_rst_sent", words_sent, 0);
    reset = 1'b0;
    repeat (3) tick();
    check("mid_rst_nodone", done_cnt, d0);
    capture(int'($urandom_range(6, 2)), -1, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
